// File: rtl/ad1da2_sched.sv
// ad1da2_sched: fixed-period sample scheduler between the PmodAD1/PmodDA2
// serial drivers and a filter core, clocked by genclk.
// Ports: genclk, rstn (async, low), en, chsel, clr; ADC adcdav/davadc/adc0data/adc1data;
// DAC dacdav/davdac/dacdata/daccmd; filter smp_*/flt_*; flags overrun/timeout/miss_cnt.
// Optional macro SCHED_TIMEOUT_EN builds the converter wait timeout.
module ad1da2_sched #(
  parameter int PERIOD  = 50,
  parameter int TIMEOUT = 40
) (
  input  logic        genclk,
  input  logic        rstn,
  input  logic        en,
  input  logic        chsel,
  input  logic        clr,
  output logic        adcdav,
  input  logic        davadc,
  input  logic [11:0] adc0data,
  input  logic [11:0] adc1data,
  output logic        dacdav,
  input  logic        davdac,
  output logic [11:0] dacdata,
  output logic [1:0]  daccmd,
  output logic [11:0] smp_data,
  output logic        smp_valid,
  input  logic        smp_ready,
  input  logic [11:0] flt_data,
  input  logic        flt_valid,
  output logic        overrun,
  output logic        timeout,
  output logic [7:0]  miss_cnt
);

  typedef enum logic [2:0] {
    IDLE, ADC_REQ, FLT_OUT, FLT_IN, DAC_REQ, DONE
  } state_t;

  localparam logic [15:0] PLAST = 16'(PERIOD - 1);

  state_t      state;
  state_t      state_n;
  logic [15:0] pcnt;
  logic        tick;
  logic        busy_tick;
  logic        to_hit;
  logic        adcdav_n;
  logic        dacdav_n;
  logic        smp_valid_n;

  assign tick      = en && (pcnt == PLAST);
  assign busy_tick = tick && (state != IDLE);
  assign daccmd    = 2'b00;

  always_ff @(posedge genclk or negedge rstn) begin
    if (!rstn)
      pcnt <= '0;
    else if (!en || tick)
      pcnt <= '0;
    else
      pcnt <= pcnt + 16'd1;
  end

`ifdef SCHED_TIMEOUT_EN
  localparam logic [15:0] TLAST = 16'(TIMEOUT - 1);

  logic [15:0] wcnt;
  logic        waiting;

  // Counts cycles spent waiting in a request state; cleared on any
  // state change so each request starts from zero.
  assign waiting = (state == ADC_REQ && !davadc) ||
                   (state == DAC_REQ && !davdac);
  assign to_hit  = waiting && (wcnt == TLAST);

  always_ff @(posedge genclk or negedge rstn) begin
    if (!rstn)
      wcnt <= '0;
    else if (state_n != state)
      wcnt <= '0;
    else if (waiting)
      wcnt <= wcnt + 16'd1;
  end
`else
  localparam int unused_timeout = TIMEOUT;
  assign to_hit = 1'b0;
`endif

  always_ff @(posedge genclk or negedge rstn) begin
    if (!rstn)
      state <= IDLE;
    else
      state <= state_n;
  end

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:    if (tick) state_n = ADC_REQ;
      ADC_REQ: if (davadc) state_n = FLT_OUT;
               else if (to_hit) state_n = DONE;
      FLT_OUT: if (smp_ready) state_n = FLT_IN;
      FLT_IN:  if (flt_valid) state_n = DAC_REQ;
      DAC_REQ: if (davdac || to_hit) state_n = DONE;
      DONE:    if (!davadc && !davdac) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Decoded from the next state so the handshake outputs leave a flop.
  always_comb begin
    adcdav_n    = (state_n == ADC_REQ);
    dacdav_n    = (state_n == DAC_REQ);
    smp_valid_n = (state_n == FLT_OUT);
  end

  always_ff @(posedge genclk or negedge rstn) begin
    if (!rstn) begin
      adcdav    <= 1'b0;
      dacdav    <= 1'b0;
      smp_valid <= 1'b0;
      smp_data  <= '0;
      dacdata   <= '0;
      overrun   <= 1'b0;
      timeout   <= 1'b0;
      miss_cnt  <= '0;
    end else begin
      adcdav    <= adcdav_n;
      dacdav    <= dacdav_n;
      smp_valid <= smp_valid_n;
      if (state == ADC_REQ && davadc)
        smp_data <= chsel ? adc1data : adc0data;
      if (state == FLT_IN && flt_valid)
        dacdata <= flt_data;
      // A skipped tick outranks a clear in the same cycle.
      if (busy_tick) begin
        overrun <= 1'b1;
        if (miss_cnt != 8'hFF)
          miss_cnt <= miss_cnt + 8'd1;
      end else if (clr) begin
        overrun  <= 1'b0;
        miss_cnt <= '0;
      end
      if (to_hit)
        timeout <= 1'b1;
      else if (clr)
        timeout <= 1'b0;
    end
  end

endmodule

// File: tb/tb_ad1da2_sched.sv
// tb_ad1da2_sched: randomized and directed bench for ad1da2_sched
// checked every cycle against a transaction-level reference model.
module tb_ad1da2_sched;

  localparam int PERIOD  = 50;
  localparam int TIMEOUT = 40;
`ifdef SCHED_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic        genclk = 1'b0;
  logic        rstn = 1'b0;
  logic        en = 1'b0;
  logic        chsel = 1'b0;
  logic        clr = 1'b0;
  logic        davadc = 1'b0;
  logic        davdac = 1'b0;
  logic        smp_ready = 1'b0;
  logic        flt_valid = 1'b0;
  logic [11:0] adc0data = '0;
  logic [11:0] adc1data = '0;
  logic [11:0] flt_data = '0;
  logic        adcdav, dacdav, smp_valid, overrun, timeout;
  logic [11:0] dacdata, smp_data;
  logic [1:0]  daccmd;
  logic [7:0]  miss_cnt;

  int vectors = 0;
  int miscompares = 0;

  always #5 genclk = ~genclk;

  ad1da2_sched #(.PERIOD(PERIOD), .TIMEOUT(TIMEOUT)) dut (
    .genclk(genclk), .rstn(rstn), .en(en), .chsel(chsel), .clr(clr),
    .adcdav(adcdav), .davadc(davadc),
    .adc0data(adc0data), .adc1data(adc1data),
    .dacdav(dacdav), .davdac(davdac), .dacdata(dacdata), .daccmd(daccmd),
    .smp_data(smp_data), .smp_valid(smp_valid), .smp_ready(smp_ready),
    .flt_data(flt_data), .flt_valid(flt_valid),
    .overrun(overrun), .timeout(timeout), .miss_cnt(miss_cnt)
  );

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- responders ----------------
  int adc_dly = 0, dac_dly = 0, flt_dly = 0, rdy_dly = 0;
  bit adc_stuck = 0, dac_stuck = 0, hold_ready = 0, rnd = 0, noise = 0;
  int acnt = 0, dcnt = 0, rcnt = 0, fcnt = 0;
  bit pend = 0, hs = 0;

  function automatic int pick();
    return ($urandom_range(0, 15) == 0) ? int'($urandom_range(30, 70))
                                        : int'($urandom_range(0, 8));
  endfunction

  always @(negedge genclk) begin
    if (rnd) begin
      chsel    = 1'($urandom);
      adc0data = 12'($urandom);
      adc1data = 12'($urandom);
      flt_data = 12'($urandom);
    end
    if (adcdav) begin
      if (acnt == 0 && rnd) adc_dly = pick();
      acnt++;
      davadc = !adc_stuck && (acnt > adc_dly);
    end else begin
      acnt = 0;
      davadc = noise && ($urandom_range(0, 15) == 0);
    end
    if (dacdav) begin
      if (dcnt == 0 && rnd) dac_dly = pick();
      dcnt++;
      davdac = !dac_stuck && (dcnt > dac_dly);
    end else begin
      dcnt = 0;
      davdac = noise && ($urandom_range(0, 15) == 0);
    end
    if (hs) begin
      pend = 1;
      fcnt = 0;
      if (rnd) flt_dly = int'($urandom_range(0, 6));
    end
    if (pend) begin
      fcnt++;
      flt_valid = (fcnt > flt_dly);
      if (flt_valid) pend = 0;
    end else begin
      flt_valid = noise && ($urandom_range(0, 7) == 0);
    end
    if (smp_valid) begin
      if (rcnt == 0 && rnd) rdy_dly = int'($urandom_range(0, 6));
      rcnt++;
      smp_ready = !hold_ready && (rcnt > rdy_dly);
    end else begin
      rcnt = 0;
      smp_ready = noise && ($urandom_range(0, 3) == 0);
    end
    hs = smp_valid && smp_ready;
  end

  // ---------------- reference model ----------------
  typedef enum {M_IDLE, M_ADC, M_SMP, M_FLT, M_DAC, M_DONE} ph_t;
  ph_t         ph = M_IDLE;
  int          run = 0, wt = 0, e_miss = 0;
  logic [11:0] e_smp = '0, e_dac = '0;
  bit          e_ovr = 0, e_to = 0, m_tick = 0, m_to = 0;

  always @(posedge genclk or negedge rstn) begin
    if (!rstn) begin
      ph = M_IDLE; run = 0; wt = 0; e_miss = 0;
      e_smp = '0; e_dac = '0; e_ovr = 0; e_to = 0;
    end else begin
      m_tick = en && (run % PERIOD == PERIOD - 1);
      run = en ? run + 1 : 0;
      m_to = 0;
      if (m_tick && ph != M_IDLE) begin
        e_ovr = 1;
        e_miss = (e_miss >= 255) ? 255 : e_miss + 1;
      end else if (clr) begin
        e_ovr = 0;
        e_miss = 0;
      end
      case (ph)
        M_IDLE: if (m_tick) begin ph = M_ADC; wt = 0; end
        M_ADC:
          if (davadc) begin
            e_smp = chsel ? adc1data : adc0data;
            ph = M_SMP;
          end else begin
            wt++;
            if (TO_EN && wt >= TIMEOUT) begin m_to = 1; ph = M_DONE; end
          end
        M_SMP: if (smp_ready) ph = M_FLT;
        M_FLT: if (flt_valid) begin e_dac = flt_data; ph = M_DAC; wt = 0; end
        M_DAC:
          if (davdac) ph = M_DONE;
          else begin
            wt++;
            if (TO_EN && wt >= TIMEOUT) begin m_to = 1; ph = M_DONE; end
          end
        default: if (!davadc && !davdac) ph = M_IDLE;
      endcase
      if (m_to) e_to = 1;
      else if (clr) e_to = 0;
    end
  end

  always @(negedge genclk) begin
    chk("adcdav", adcdav, ph == M_ADC);
    chk("dacdav", dacdav, ph == M_DAC);
    chk("smp_valid", smp_valid, ph == M_SMP);
    chk("smp_data", smp_data, e_smp);
    chk("dacdata", dacdata, e_dac);
    chk("daccmd", daccmd, 0);
    chk("overrun", overrun, e_ovr);
    chk("timeout", timeout, e_to);
    chk("miss_cnt", miss_cnt, e_miss);
  end

  // ---------------- directed + random sequence ----------------
  function automatic logic sig(input int w);
    case (w)
      0:       return adcdav;
      1:       return smp_valid;
      default: return dacdav;
    endcase
  endfunction

  task automatic wait_for(input int w, input logic lvl, input int lim,
                          input string nm);
    int k = 0;
    while (sig(w) !== lvl && k < lim) begin
      @(negedge genclk);
      k++;
    end
    chk(nm, sig(w), lvl);
  endtask

  task automatic count_rises(input int n, output int r);
    logic p;
    r = 0;
    p = adcdav;
    repeat (n) begin
      @(negedge genclk);
      if (adcdav && !p) r++;
      p = adcdav;
    end
  endtask

  task automatic first_tick(input string nm);
    int k = 0;
    while (!adcdav && k < 4 * PERIOD) begin
      @(posedge genclk);
      #1;
      k++;
    end
    chk(nm, k, PERIOD);
  endtask

  int r;

  initial begin
    repeat (3) @(negedge genclk);
    chk("rst_adcdav", adcdav, 0);
    chk("rst_miss", miss_cnt, 0);
    adc_dly = 5; dac_dly = 4; flt_dly = 0; rdy_dly = 0;
    chsel = 0; adc0data = 12'hABC; adc1data = 12'h0FF; flt_data = 12'h123;
    rstn = 1; en = 1;
    first_tick("first_tick");

    wait_for(2, 1, 2 * PERIOD, "basic_dac_up");
    wait_for(2, 0, 2 * PERIOD, "basic_dac_down");
    chk("basic_smp", smp_data, 12'hABC);
    chk("basic_dac", dacdata, 12'h123);
    chk("basic_ovr", overrun, 0);
    count_rises(2 * PERIOD, r);
    chk("basic_rate", r, 2);

    chsel = 1; adc1data = 12'h5A5; adc0data = 12'h000;
    wait_for(1, 1, 2 * PERIOD, "chan_valid");
    chk("chan_smp", smp_data, 12'h5A5);
    wait_for(2, 1, 2 * PERIOD, "chan_dac_up");
    wait_for(2, 0, 2 * PERIOD, "chan_dac_down");

    clr = 1; @(negedge genclk); clr = 0;
    hold_ready = 1;
    wait_for(1, 1, 2 * PERIOD, "ovr_valid");
    count_rises(120, r);
    chk("ovr_no_req", r, 0);
    chk("ovr_flag", overrun, 1);
    chk("ovr_miss", miss_cnt, 2);
    hold_ready = 0;
    wait_for(2, 1, PERIOD, "ovr_dac_up");
    wait_for(2, 0, PERIOD, "ovr_dac_down");
    clr = 1; @(negedge genclk); clr = 0;
    chk("clr_ovr", overrun, 0);
    chk("clr_miss", miss_cnt, 0);

    adc_stuck = 1;
    wait_for(0, 1, 2 * PERIOD, "to_req");
    r = 0;
    while (adcdav && r < 100) begin
      @(negedge genclk);
      r++;
    end
    if (TO_EN) begin
      chk("to_len", r, TIMEOUT);
      chk("to_flag", timeout, 1);
      adc_stuck = 0;
      wait_for(0, 1, 2 * PERIOD, "to_retry");
    end else begin
      chk("to_hold", r, 100);
      chk("to_flag0", timeout, 0);
      adc_stuck = 0;
    end
    wait_for(2, 1, 2 * PERIOD, "to_dac_up");
    wait_for(2, 0, 2 * PERIOD, "to_dac_down");

    dac_dly = 20;
    wait_for(2, 1, 3 * PERIOD, "rst_dac_up");
    repeat (2) @(negedge genclk);
    #2 rstn = 0;
    #1;
    chk("arst_dacdav", dacdav, 0);
    chk("arst_adcdav", adcdav, 0);
    chk("arst_valid", smp_valid, 0);
    chk("arst_ovr", overrun, 0);
    chk("arst_to", timeout, 0);
    chk("arst_miss", miss_cnt, 0);
    chk("arst_dacdata", dacdata, 0);
    @(negedge genclk);
    dac_dly = 4; flt_dly = 10;
    rstn = 1;
    first_tick("rst_first_tick");

    wait_for(1, 1, PERIOD, "en_valid");
    wait_for(1, 0, PERIOD, "en_accept");
    en = 0;
    wait_for(2, 1, PERIOD, "en_dac_up");
    wait_for(2, 0, PERIOD, "en_dac_down");
    chk("en_dacdata", dacdata, 12'h123);
    count_rises(3 * PERIOD, r);
    chk("en_no_req", r, 0);
    en = 1;

    rnd = 1; noise = 1;
    for (int i = 0; i < 5000; i++) begin
      @(negedge genclk);
      if ($urandom_range(0, 399) == 0) en = ~en;
      clr = ($urandom_range(0, 63) == 0);
    end
    rnd = 0; noise = 0; clr = 0; en = 1;
    adc_dly = 2; dac_dly = 2; flt_dly = 0; rdy_dly = 0;

    hold_ready = 1;
    wait_for(1, 1, 8 * PERIOD, "sat_valid");
    repeat (258 * PERIOD) @(negedge genclk);
    chk("sat_miss", miss_cnt, 255);
    chk("sat_ovr", overrun, 1);
    hold_ready = 0;
    wait_for(2, 1, PERIOD, "sat_dac_up");
    wait_for(2, 0, PERIOD, "sat_dac_down");
    repeat (5) @(negedge genclk);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
